// File: rtl/cnn_weight_loader.sv
// cnn_weight_loader: double-buffered weight store for one CNN layer.
//
// A stream of 32-bit words fills a shadow bank. Bit 31 of a word flags the
// start of a set, and bits [WEIGHT_BITS-1:0] carry the weight. Once the last
// word of a set has been accepted, the loader stalls upstream until the served
// layer reports that it is between images. The whole shadow bank is then
// copied to the active bank in a single edge, which drives weights_o. As a
// result, weights_o can only change between images.
//
// Ports:
//   clock_i          - single clock, rising edge
//   reset_i          - synchronous, active-high reset
//   in_data_i        - [31] start-of-set flag, [WEIGHT_BITS-1:0] weight
//   in_valid_i       - in_data_i valid this cycle
//   upstream_stall_o - word not accepted this cycle (set is complete and awaiting commit)
//   layer_idle_i     - served layer is between images
//   weights_o        - active bank, indexed [oc][ic][x][y]
//   weights_valid_o  - active bank holds a committed set
//   commit_o         - one-cycle pulse after a new set became active
//   error_o          - sticky protocol error (stray data word or restarted set)
//   load_count_o     - words accepted into the shadow bank for the current set
module cnn_weight_loader #(
   parameter int unsigned WEIGHT_BITS  = 16,
   parameter int unsigned KERNAL_SIZE  = 3,
   parameter int unsigned IN_CHANNELS  = 1,
   parameter int unsigned OUT_CHANNELS = 3
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic [31:0]             in_data_i,
   input  logic                    in_valid_i,
   output logic                    upstream_stall_o,
   input  logic                    layer_idle_i,
   output logic [OUT_CHANNELS-1:0][IN_CHANNELS-1:0][KERNAL_SIZE-1:0][KERNAL_SIZE-1:0]
                [WEIGHT_BITS-1:0] weights_o,
   output logic                    weights_valid_o,
   output logic                    commit_o,
   output logic                    error_o,
   output logic [7:0]              load_count_o
);

   localparam int unsigned N_WEIGHTS = OUT_CHANNELS * IN_CHANNELS * KERNAL_SIZE * KERNAL_SIZE;
   localparam logic [7:0]  LAST_IDX  = 8'(N_WEIGHTS - 1);

   // Flat bank with the same bit layout as weights_o: because y is the
   // innermost (fastest) packed dimension, flat index k equals
   // ((oc*IN_CHANNELS+ic)*KERNAL_SIZE+x)*KERNAL_SIZE+y.
   typedef logic [N_WEIGHTS-1:0][WEIGHT_BITS-1:0] bank_t;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_COMMIT} state_e;

   state_e     state_q, state_d;
   bank_t      shadow_q, shadow_d;
   bank_t      active_q, active_d;
   logic [7:0] count_q, count_d;
   logic       valid_q, valid_d;
   logic       commit_q, commit_d;
   logic       error_q, error_d;

   logic                   accept;
   logic                   start_flag;
   logic [WEIGHT_BITS-1:0] weight;
   logic                   wr_en;
   logic [7:0]             wr_idx;

   assign accept     = in_valid_i && (state_q != S_WAIT_COMMIT);
   assign start_flag = in_data_i[31];
   assign weight     = in_data_i[WEIGHT_BITS-1:0];

   // Bits between the weight field and the start flag carry no meaning.
   if (WEIGHT_BITS < 31) begin : g_unused
      logic unused_data;
      assign unused_data = ^in_data_i[30:WEIGHT_BITS];
   end

   // State register
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && start_flag) begin
               state_d = (N_WEIGHTS == 1) ? S_WAIT_COMMIT : S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (start_flag) begin
                  state_d = (N_WEIGHTS == 1) ? S_WAIT_COMMIT : S_LOAD;
               end else if (count_q == LAST_IDX) begin
                  state_d = S_WAIT_COMMIT;
               end
            end
         end
         S_WAIT_COMMIT: begin
            if (layer_idle_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = 8'd0;
      count_d  = count_q;
      error_d  = error_q;
      valid_d  = valid_q;
      commit_d = 1'b0;
      active_d = active_q;
      shadow_d = shadow_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (start_flag) begin
                  wr_en   = 1'b1;
                  count_d = 8'd1;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               wr_en = 1'b1;
               if (start_flag) begin
                  // A start word mid-set abandons the partial set and restarts it.
                  count_d = 8'd1;
                  error_d = 1'b1;
               end else begin
                  wr_idx  = count_q;
                  count_d = count_q + 8'd1;
               end
            end
         end
         S_WAIT_COMMIT: begin
            if (layer_idle_i) begin
               active_d = shadow_q;
               valid_d  = 1'b1;
               commit_d = 1'b1;
               count_d  = 8'd0;
            end
         end
         default: ;
      endcase
      for (int k = 0; k < int'(N_WEIGHTS); k++) begin
         if (wr_en && (wr_idx == k[7:0])) begin
            shadow_d[k] = weight;
         end
      end
   end

   // Shadow bank is deliberately not reset; a new set always begins with a start word.
   always_ff @(posedge clock_i) begin
      shadow_q <= shadow_d;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         active_q <= '0;
         count_q  <= 8'd0;
         valid_q  <= 1'b0;
         commit_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         active_q <= active_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         commit_q <= commit_d;
         error_q  <= error_d;
      end
   end

   // Outputs
   always_comb begin
      upstream_stall_o = (state_q == S_WAIT_COMMIT);
      weights_o        = active_q;
      weights_valid_o  = valid_q;
      commit_o         = commit_q;
      error_o          = error_q;
      load_count_o     = count_q;
   end

endmodule

// File: tb/tb_cnn_weight_loader.sv
// Self-checking bench for cnn_weight_loader at default parameters (27 weights).
// Every set that is sent is pushed to a scoreboard queue. Each commit_o pulse
// pops one set and compares the whole active bank against it.
module tb_cnn_weight_loader;

   localparam int WB = 16;
   localparam int K  = 3;
   localparam int IC = 1;
   localparam int OC = 3;
   localparam int N  = OC * IC * K * K;

   typedef logic [N-1:0][WB-1:0] set_t;
   typedef logic [OC-1:0][IC-1:0][K-1:0][K-1:0][WB-1:0] w_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = 32'd0;
   logic        in_valid = 1'b0;
   logic        stall;
   logic        layer_idle = 1'b1;
   w_t          weights;
   logic        wvalid;
   logic        commit;
   logic        error;
   logic [7:0]  load_count;

   int   vectors = 0;
   int   misc = 0;
   int   commit_cnt = 0;
   set_t exp_q[$];

   cnn_weight_loader #(
      .WEIGHT_BITS (WB),
      .KERNAL_SIZE (K),
      .IN_CHANNELS (IC),
      .OUT_CHANNELS(OC)
   ) dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .in_data_i       (in_data),
      .in_valid_i      (in_valid),
      .upstream_stall_o(stall),
      .layer_idle_i    (layer_idle),
      .weights_o       (weights),
      .weights_valid_o (wvalid),
      .commit_o        (commit),
      .error_o         (error),
      .load_count_o    (load_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   // Scoreboard: each commit pulse consumes one expected set.
   set_t mon_exp;
   int   m_oc, m_ic, m_x, m_y;
   always @(negedge clk) begin
      if (commit === 1'b1) begin
         commit_cnt++;
         vectors++;
         if (exp_q.size() == 0) begin
            misc++;
            $display("FAIL unexpected_commit: commit_o=1 with no pending set");
         end else begin
            mon_exp = exp_q.pop_front();
            for (int k = 0; k < N; k++) begin
               m_oc = k / (IC * K * K);
               m_ic = (k / (K * K)) % IC;
               m_x  = (k / K) % K;
               m_y  = k % K;
               vectors++;
               if (weights[m_oc][m_ic][m_x][m_y] !== mon_exp[k]) begin
                  misc++;
                  $display("FAIL commit_weight[%0d][%0d][%0d][%0d]: got %0d want %0d",
                           m_oc, m_ic, m_x, m_y, weights[m_oc][m_ic][m_x][m_y], mon_exp[k]);
               end
            end
         end
      end
   end

   // Present one word until accepted; returns at the negedge after acceptance.
   task automatic send_word(input logic [31:0] w, output bit ok, output int waits);
      bit acc;
      ok = 1'b0;
      waits = 0;
      in_data = w;
      in_valid = 1'b1;
      for (int n = 0; n < 100 && !ok; n++) begin
         acc = !stall;
         @(negedge clk);
         if (acc) ok = 1'b1;
         else waits++;
      end
      if (!ok) begin
         vectors++;
         misc++;
         $display("FAIL send_timeout: word %h not accepted, required acceptance", w);
      end
   endtask

   task automatic send_set(input set_t s, output int first_waits);
      bit ok;
      int w;
      exp_q.push_back(s);
      first_waits = 0;
      for (int k = 0; k < N; k++) begin
         send_word({(k == 0), {(31 - WB){1'b0}}, s[k]}, ok, w);
         if (k == 0) first_waits = w;
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_commit(input string name);
      for (int n = 0; n < 20 && commit !== 1'b1; n++) @(negedge clk);
      vectors++;
      if (commit !== 1'b1) begin
         misc++;
         $display("FAIL %s_commit_timeout: commit_o=%b want 1", name, commit);
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (stall !== 1'b0) begin misc++; $display("FAIL reset_stall: got %b want 0", stall); end
      vectors++;
      if (load_count !== 8'd0) begin misc++; $display("FAIL reset_count: got %0d want 0", load_count); end
      vectors++;
      if (weights !== '0) begin misc++; $display("FAIL reset_weights: got %h want 0", weights); end
      vectors++;
      if ({wvalid, commit, error} !== 3'b000) begin
         misc++; $display("FAIL reset_flags: valid/commit/error got %b want 000", {wvalid, commit, error});
      end
   endtask

   task automatic test_basic();
      set_t s;
      int   fw;
      int   c0 = commit_cnt;
      layer_idle = 1'b1;
      for (int k = 0; k < N; k++) s[k] = WB'(k + 1);
      send_set(s, fw);
      vectors++;
      if (stall !== 1'b1 || commit !== 1'b0 || weights !== '0) begin
         misc++;
         $display("FAIL basic_after_last: stall=%b commit=%b weights0=%0d want 1,0,0",
                  stall, commit, weights[0][0][0][0]);
      end
      @(negedge clk);
      vectors++;
      if (commit !== 1'b1) begin misc++; $display("FAIL basic_latency: commit_o=%b want 1", commit); end
      vectors++;
      if (weights[0][0][0][0] !== 16'd1 || weights[0][0][0][1] !== 16'd2
          || weights[2][0][2][2] !== 16'd27) begin
         misc++;
         $display("FAIL basic_weights: got %0d,%0d,%0d want 1,2,27", weights[0][0][0][0],
                  weights[0][0][0][1], weights[2][0][2][2]);
      end
      vectors++;
      if (wvalid !== 1'b1 || error !== 1'b0 || load_count !== 8'd0 || stall !== 1'b0) begin
         misc++;
         $display("FAIL basic_status: valid=%b error=%b count=%0d stall=%b want 1,0,0,0",
                  wvalid, error, load_count, stall);
      end
      @(negedge clk);
      vectors++;
      if (commit !== 1'b0 || commit_cnt != c0 + 1) begin
         misc++; $display("FAIL basic_one_pulse: commit=%b commits=%0d want 0,%0d", commit,
                          commit_cnt - c0, 1);
      end
   endtask

   task automatic test_stall_wait();
      set_t s;
      w_t   snap;
      int   fw;
      layer_idle = 1'b0;
      snap = weights;
      for (int k = 0; k < N; k++) s[k] = WB'(200 + k);
      send_set(s, fw);
      // A start word offered while stalled must stay with the source.
      in_data = 32'h8000_0063;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (stall !== 1'b1 || weights !== snap || commit !== 1'b0 || load_count !== 8'd27) begin
            misc++;
            $display("FAIL stall_hold_%0d: stall=%b commit=%b count=%0d same=%b want 1,0,27,1",
                     i, stall, commit, load_count, weights === snap);
         end
      end
      layer_idle = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (commit !== 1'b1 || weights[0][0][0][0] !== 16'd200) begin
         misc++;
         $display("FAIL stall_release: commit=%b w0=%0d want 1,200", commit, weights[0][0][0][0]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      set_t sa, sb;
      int   fw;
      int   c0 = commit_cnt;
      layer_idle = 1'b1;
      for (int k = 0; k < N; k++) begin
         sa[k] = WB'(300 + k);
         sb[k] = WB'(400 + k);
      end
      send_set(sa, fw);
      send_set(sb, fw);
      vectors++;
      if (fw != 1) begin misc++; $display("FAIL b2b_start_wait: got %0d cycles want 1", fw); end
      wait_commit("b2b");
      @(negedge clk);
      vectors++;
      if (commit_cnt != c0 + 2 || weights[2][0][2][2] !== 16'd426) begin
         misc++;
         $display("FAIL b2b_result: commits=%0d w_last=%0d want 2,426", commit_cnt - c0,
                  weights[2][0][2][2]);
      end
   endtask

   task automatic test_idle_error();
      bit ok;
      int w;
      int c0;
      do_reset();
      c0 = commit_cnt;
      vectors++;
      if (error !== 1'b0) begin misc++; $display("FAIL idle_err_pre: error=%b want 0", error); end
      send_word(32'h0000_0005, ok, w);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (error !== 1'b1 || load_count !== 8'd0 || stall !== 1'b0 || commit_cnt != c0) begin
         misc++;
         $display("FAIL idle_err: error=%b count=%0d stall=%b commits=%0d want 1,0,0,0",
                  error, load_count, stall, commit_cnt - c0);
      end
   endtask

   task automatic test_restart();
      set_t s;
      bit   ok;
      int   w;
      do_reset();
      layer_idle = 1'b1;
      s[0] = 16'd99;
      for (int k = 1; k < N; k++) s[k] = WB'(99 + k);
      exp_q.push_back(s);
      send_word(32'h8000_0001, ok, w);
      for (int i = 2; i <= 11; i++) send_word(32'(i), ok, w);
      vectors++;
      if (load_count !== 8'd11 || error !== 1'b0) begin
         misc++; $display("FAIL restart_partial: count=%0d error=%b want 11,0", load_count, error);
      end
      send_word(32'h8000_0063, ok, w);
      vectors++;
      if (load_count !== 8'd1 || error !== 1'b1) begin
         misc++; $display("FAIL restart_start: count=%0d error=%b want 1,1", load_count, error);
      end
      for (int k = 1; k < N; k++) send_word({16'd0, s[k]}, ok, w);
      in_valid = 1'b0;
      wait_commit("restart");
      vectors++;
      if (weights[0][0][0][0] !== 16'd99 || error !== 1'b1) begin
         misc++;
         $display("FAIL restart_result: w0=%0d error=%b want 99,1", weights[0][0][0][0], error);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      bit ok;
      int w;
      int c0 = commit_cnt;
      send_word(32'h8000_0011, ok, w);
      for (int i = 1; i < 15; i++) send_word(32'(i + 17), ok, w);
      in_valid = 1'b0;
      vectors++;
      if (load_count !== 8'd15) begin
         misc++; $display("FAIL midrst_count_pre: got %0d want 15", load_count);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (load_count !== 8'd0 || weights !== '0 || wvalid !== 1'b0 || commit !== 1'b0
             || stall !== 1'b0 || error !== 1'b0) begin
            misc++;
            $display("FAIL midrst_state_%0d: count=%0d zero=%b valid=%b commit=%b stall=%b err=%b",
                     i, load_count, weights === '0, wvalid, commit, stall, error);
         end
         @(negedge clk);
      end
      // Pending set is gone: a data word now is a protocol error, not index 15.
      send_word(32'h0000_0007, ok, w);
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (error !== 1'b1 || load_count !== 8'd0 || commit_cnt != c0) begin
         misc++;
         $display("FAIL midrst_need_start: error=%b count=%0d commits=%0d want 1,0,0",
                  error, load_count, commit_cnt - c0);
      end
   endtask

   task automatic test_random_valid();
      set_t s;
      bit   acc;
      int   k;
      int   c0;
      int   guard;
      do_reset();
      c0 = commit_cnt;
      layer_idle = 1'b1;
      for (int i = 0; i < N; i++) s[i] = WB'($urandom_range(0, 65535));
      exp_q.push_back(s);
      k = 0;
      guard = 0;
      while (k < N && guard < 2000) begin
         in_data = {(k == 0), 15'd0, s[k]};
         in_valid = 1'($urandom % 2);
         acc = in_valid && !stall;
         @(negedge clk);
         if (acc) k++;
         guard++;
      end
      in_valid = 1'b0;
      vectors++;
      if (k != N) begin misc++; $display("FAIL random_feed: sent %0d words want %0d", k, N); end
      wait_commit("random");
      repeat (3) @(negedge clk);
      vectors++;
      if (commit_cnt != c0 + 1 || wvalid !== 1'b1 || error !== 1'b0) begin
         misc++;
         $display("FAIL random_result: commits=%0d valid=%b error=%b want 1,1,0",
                  commit_cnt - c0, wvalid, error);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_stall_wait();
      test_back_to_back();
      test_idle_error();
      test_restart();
      test_reset_mid_load();
      test_random_valid();
      vectors++;
      if (exp_q.size() != 0) begin
         misc++; $display("FAIL scoreboard_drain: %0d sets pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end

endmodule

// File: doc/cnn_weight_loader.md
CNN_WEIGHT_LOADER -- requirements
Module: cnn_weight_loader

Interface
REQ-001 Parameter: WEIGHT_BITS, 16, width of one fixed-point weight (SHALL be <= 31).
REQ-002 Parameter: KERNAL_SIZE, 3, kernal height and width.
REQ-003 Parameter: IN_CHANNELS, 1, input channels of the served cnn layer.
REQ-004 Parameter: OUT_CHANNELS, 3, output channels of the served cnn layer.
REQ-005 Derived: N_WEIGHTS = OUT_CHANNELS*IN_CHANNELS*KERNAL_SIZE*KERNAL_SIZE, which SHALL be <= 255.
REQ-006 clock_i  in  1  single clock; all state changes on its rising edge.
REQ-007 reset_i  in  1  synchronous, active-high reset.
REQ-008 in_data_i  in  32  weight word: bit 31 is the start-of-set flag, bits [WEIGHT_BITS-1:0] are the weight, and the remaining bits are ignored.
REQ-009 in_valid_i  in  1  in_data_i is valid this cycle.
REQ-010 upstream_stall_o  out  1  word not accepted this cycle.
REQ-011 layer_idle_i  in  1  served layer is between images, so weights may change.
REQ-012 weights_o  out  WEIGHT_BITS x [OUT_CHANNELS][IN_CHANNELS][KERNAL_SIZE][KERNAL_SIZE]  active weight bank.
REQ-013 weights_valid_o  out  1  active bank holds a committed set.
REQ-014 commit_o  out  1  one-cycle pulse: a new set became active.
REQ-015 error_o  out  1  sticky: a protocol error was seen.
REQ-016 load_count_o  out  8  number of words accepted into the shadow bank for the current set.

Function
REQ-017 The block SHALL hold two banks:
- a shadow bank, written by the stream and not reset;
- an active bank, driving weights_o.
REQ-018 States SHALL be S_IDLE, S_LOAD and S_WAIT_COMMIT.
REQ-019 A word SHALL be accepted when in_valid_i=1 and upstream_stall_o=0.
REQ-020 upstream_stall_o SHALL be 1 exactly when the state is S_WAIT_COMMIT (combinational from state).
REQ-021 Word index k SHALL be written to shadow[oc][ic][x][y] with k = ((oc*IN_CHANNELS+ic)*KERNAL_SIZE+x)*KERNAL_SIZE+y, i.e. y varies fastest.
REQ-022 S_IDLE, accepted word with bit31=1: the word SHALL be written as index 0, load_count becomes 1, and the state becomes S_LOAD.
REQ-023 S_IDLE, accepted word with bit31=0: the word SHALL be dropped, error_o set, and the state stays S_IDLE.
REQ-024 S_LOAD, accepted word with bit31=0: the word SHALL be written at index load_count and load_count incremented.
REQ-025 S_LOAD, accepted word with bit31=1: the set SHALL restart, writing the word as index 0 with load_count=1, and error_o set.
REQ-026 When the word at index N_WEIGHTS-1 is accepted, the state SHALL become S_WAIT_COMMIT on the same edge.
REQ-027 N_WEIGHTS=1: a start word SHALL go directly from S_IDLE to S_WAIT_COMMIT.
REQ-028 S_WAIT_COMMIT with layer_idle_i=1 sampled at an edge: on that edge the block SHALL
- copy the whole shadow bank to the active bank;
- set weights_valid_o=1;
- drive commit_o=1 for the following cycle only;
- clear load_count to 0;
- return to S_IDLE.
REQ-029 S_WAIT_COMMIT with layer_idle_i=0: the block SHALL wait indefinitely with all outputs held.
REQ-030 Minimum latency SHALL be as follows, with the last word accepted at edge t and layer_idle_i=1:
- new weights_o are visible after edge t+1;
- commit_o is high during the cycle after edge t+1.
REQ-031 weights_o SHALL change only on a commit edge and never mid-image.
REQ-032 Words presented while stalled SHALL NOT be consumed; the source holds them.
REQ-033 A new start word MAY be accepted in the cycle immediately after a commit.
REQ-034 error_o SHALL clear only on reset.

Reset
REQ-035 On reset_i=1 at an edge the block SHALL set:
- state S_IDLE;
- load_count_o=0;
- every weights_o element to 0;
- weights_valid_o=0;
- commit_o=0;
- error_o=0.
REQ-036 Reset mid-load or in S_WAIT_COMMIT SHALL discard the partial or pending set; the next set SHALL require a new start word.
REQ-037 upstream_stall_o SHALL be 0 in the cycle after reset.

Verification
REQ-038 Defaults (N=27), 27 back-to-back words with values 1..27 (first word 0x8000_0001), layer_idle_i=1:
- weights_o[0][0][0][0]=1;
- weights_o[0][0][0][1]=2;
- weights_o[2][0][2][2]=27;
- one commit_o pulse, weights_valid_o=1, error_o=0.
REQ-039 Full set loaded with layer_idle_i=0 for 10 cycles:
- upstream_stall_o=1 and weights_o unchanged for those cycles;
- the commit lands on the first edge with layer_idle_i=1.
REQ-040 Word 0x0000_0005 in S_IDLE: error_o=1, load_count_o stays 0, no commit.
REQ-041 Start word, 10 data words, then a new start word followed by 26 words valued 100..125 plus the start word's weight 99:
- error_o=1;
- committed weights_o[0][0][0][0]=99.
REQ-042 reset_i pulsed after 15 accepted words: load_count_o=0, weights_o all 0, weights_valid_o=0, no commit_o.
REQ-043 in_valid_i toggled 50% random during a load: every weight lands at the correct index and exactly one commit_o occurs.
